// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes
// and the funct3 legality check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_f3(input logic store, input logic [2:0] f3);
    logic legal;
    legal = 1'b0;
    if (store) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    end
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: load extract/extend and sub-word store merge.
// The memory returns the bytes starting at the access address, so no shifting is needed.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        funct3,
  input  logic [DWIDTH-1:0] raw,
  input  logic [DWIDTH-9:0] old_hi,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] load_data,
  output logic [DWIDTH-1:0] store_data
);

  always_comb begin
    load_data = raw;
    case (funct3)
      F3_B:    load_data = {{(DWIDTH-8){raw[7]}}, raw[7:0]};
      F3_H:    load_data = {{(DWIDTH-16){raw[15]}}, raw[15:0]};
      F3_BU:   load_data = {{(DWIDTH-8){1'b0}}, raw[7:0]};
      F3_HU:   load_data = {{(DWIDTH-16){1'b0}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

  // old_hi is the previously read word without its lowest byte
  always_comb begin
    store_data = wdata;
    case (funct3)
      F3_B:    store_data = {old_hi, wdata[7:0]};
      F3_H:    store_data = {old_hi[DWIDTH-9:8], wdata[15:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, sub-word stores done as read-modify-write.
// Responses are held until consumed; a new request is taken only from IDLE.
module lsu
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  lsu_state_e        state, state_nxt;
  logic [2:0]        f3_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-9:0] old_hi_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;
  logic [DWIDTH-1:0] load_data;
  logic [DWIDTH-1:0] store_data;
  logic              req_legal;

  assign req_legal = is_legal_f3(req_store_i, req_funct3_i);

  lsu_align #(.DWIDTH(DWIDTH)) u_align (
    .funct3    (f3_q),
    .raw       (mem_rdata_i),
    .old_hi    (old_hi_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .store_data(store_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (!req_legal)                  state_nxt = RESP;
          else if (!req_store_i)           state_nxt = LOAD;
          else if (req_funct3_i == F3_W)   state_nxt = WRITE;
          else                             state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_hi_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid_i) begin
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        err_q   <= !req_legal;
      end
      if (state == LOAD)   rdata_q  <= load_data;
      if (state == RMW_RD) old_hi_q <= mem_rdata_i[DWIDTH-1:8];
    end
  end

  // Enables are gated by rst so a reset landing mid-access never touches memory
  assign req_ready_o    = (state == IDLE) && !rst;
  assign rsp_valid_o    = (state == RESP);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = (state == WRITE) ? store_data : '0;
  assign mem_read_en_o  = ((state == LOAD) || (state == RMW_RD)) && !rst;
  assign mem_write_en_o = (state == WRITE) && !rst;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-addressable memory model and a response scoreboard.
module tb_lsu;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_store_i   (req_store),
    .req_funct3_i  (req_funct3),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_read_en_o (mem_read_en),
    .mem_write_en_o(mem_write_en),
    .mem_rdata_i   (mem_rdata)
  );

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit init_mem = 1'b1;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;

  // 256-byte window of memory starting at BASE
  logic [7:0]  mem [0:255];
  logic [31:0] off;
  logic [7:0]  o;
  assign off = mem_addr - BASE;
  assign o   = off[7:0];

  always_comb mem_rdata = {mem[o + 8'd3], mem[o + 8'd2], mem[o + 8'd1], mem[o]};

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hBB; mem[8'h11] <= 8'hAA; mem[8'h12] <= 8'h99; mem[8'h13] <= 8'h88;
      mem[8'h30] <= 8'h44; mem[8'h31] <= 8'h33; mem[8'h32] <= 8'h22; mem[8'h33] <= 8'h11;
    end else if (mem_write_en) begin
      mem[o]        <= mem_wdata[7:0];
      mem[o + 8'd1] <= mem_wdata[15:8];
      mem[o + 8'd2] <= mem_wdata[23:16];
      mem[o + 8'd3] <= mem_wdata[31:24];
    end
    if (mem_read_en)  rd_cnt <= rd_cnt + 1;
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response handshake is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response", rsp_rdata, rsp_err);
      end else begin
        exp_e = exp_q.pop_front();
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e[32]});
        chk("rsp_rdata", rsp_rdata, exp_e[31:0]);
      end
    end
  end

  // Returns #1 after the accepting edge; waited counts idle cycles spent for req_ready
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int waited);
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got req_ready 0, required 1");
    end
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) until rsp_valid shows
  task automatic wait_rsp(input string nm, input int exp_lat, output int wr_at);
    int n;
    n = 1;
    wr_at = 0;
    while (!rsp_valid && n <= 10) begin
      if (mem_write_en && wr_at == 0) wr_at = n;
      @(posedge clk);
      #1 n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int w, wa, r0, w0;
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int w, wa, r0, w0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_en", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    init_mem = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    exp_q.push_back({1'b0, 32'hFFFF_FF88});
    issue(1'b0, 3'b000, BASE + 32'h13, 32'h0, w);
    wait_rsp("lb", 2, wa);

    exp_q.push_back({1'b0, 32'h0000_0088});
    issue(1'b0, 3'b100, BASE + 32'h13, 32'h0, w);
    wait_rsp("lbu", 2, wa);

    exp_q.push_back({1'b0, 32'hFFFF_8899});
    issue(1'b0, 3'b001, BASE + 32'h12, 32'h0, w);
    wait_rsp("lh", 2, wa);

    w0 = wr_cnt;
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b000, BASE + 32'h11, 32'h1234_565A, w);
    wait_rsp("sb", 3, wa);
    chk("sb_write_cycle", 32'(wa), 32'd2);
    chk("sb_write_count", 32'(wr_cnt - w0), 32'd1);
    chk("sb_mem_bytes", {mem[8'h14], mem[8'h13], mem[8'h12], mem[8'h11]}, 32'h0088_995A);

    exp_q.push_back({1'b0, 32'h8899_5ABB});
    issue(1'b0, 3'b010, BASE + 32'h10, 32'h0, w);
    rsp_ready = 1'b0;
    wait_rsp("lw_hold", 2, wa);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h8899_5ABB);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_hs_req_ready", {31'b0, req_ready}, 32'd1);
    chk("after_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    w0 = wr_cnt;
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b010, BASE + 32'h20, 32'hDEAD_BEEF, w);
    chk("next_req_no_wait", 32'(w), 32'd0);
    wait_rsp("sw", 2, wa);
    chk("sw_write_cycle", 32'(wa), 32'd1);
    chk("sw_write_count", 32'(wr_cnt - w0), 32'd1);

    exp_q.push_back({1'b0, 32'h0000_DEAD});
    issue(1'b0, 3'b101, BASE + 32'h22, 32'h0, w);
    wait_rsp("lhu", 2, wa);

    r0 = rd_cnt;
    w0 = wr_cnt;
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 3'b011, BASE + 32'h10, 32'h0, w);
    wait_rsp("err", 1, wa);
    @(posedge clk);
    #1;
    chk("err_no_read", 32'(rd_cnt - r0), 32'd0);
    chk("err_no_write", 32'(wr_cnt - w0), 32'd0);

    issue(1'b1, 3'b001, BASE + 32'h30, 32'hFFFF_5555, w);
    @(posedge clk);
    #1 chk("sh_in_write", {31'b0, mem_write_en}, 32'd1);
    rst = 1'b1;
    #1 chk("rst_gates_write", {31'b0, mem_write_en}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_mem_en", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    chk("midrst_mem_unchanged", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h1122_3344);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);

    exp_q.push_back({1'b0, 32'h1122_3344});
    issue(1'b0, 3'b010, BASE + 32'h30, 32'h0, w);
    wait_rsp("lw_after_rst", 2, wa);
    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
